// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and baud-divider sizing helpers.
// Also imported by uart_transmitter so both ends agree on divider arithmetic.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  // Clocks per oversample tick, truncated.
  function automatic int baud_div(input int clk_freq, input int baud_rate, input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

  // Bits needed for a counter running 0..n-1 (never less than 1).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-side UART bundle: serial input plus the deserialised word and status pulses.
// master = the receiver itself, slave = whoever drives RxD and consumes the results.
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic                 RxD;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 framing_err;
  logic                 parity_err;
  logic                 busy;

  modport master (
    input  RxD,
    output data, data_valid, framing_err, parity_err, busy
  );

  modport slave (
    output RxD,
    input  data, data_valid, framing_err, parity_err, busy
  );
endinterface

// File: rtl/uart_baud_tick_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks, phase reset by restart.
module uart_baud_tick_gen
  import uart_pkg::*;
#(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int            W        = cnt_width(DIV);
  localparam logic [W-1:0]  CNT_LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    tick  = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive path with 16x-style oversampling and 2-of-3 majority vote per bit.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input logic             clk,
  input logic             reset,
  uart_receiver_if.master rx_if
);
  localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TW  = cnt_width(OVERSAMPLE);
  localparam int BW  = cnt_width(DATA_BITS);

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] TICK_RES  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [1:0]           rx_sync_q;
  logic                 rx_prev_q;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 s0_q, s0_d, s1_q, s1_d;
  logic                 data_valid_q, data_valid_d;
  logic                 framing_err_q, framing_err_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
`endif

  logic rx_s;
  logic start_edge;
  logic restart;
  logic tick;
  logic resolve;
  logic end_of_bit;
  logic bit_val;

  assign rx_s       = rx_sync_q[1];
  assign start_edge = rx_prev_q & ~rx_s;
  assign restart    = (state_q == ST_IDLE) && start_edge;
  assign resolve    = tick && (tick_cnt_q == TICK_RES);
  assign end_of_bit = tick && (tick_cnt_q == TICK_LAST);
  // Third vote is the live sample taken at the resolve tick itself.
  assign bit_val    = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

  uart_baud_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    data_d        = data_q;
    s0_d          = s0_q;
    s1_d          = s1_q;
    data_valid_d  = 1'b0;
    framing_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d     = par_bad_q;
    parity_err_d  = 1'b0;
`endif
    tick_cnt_d    = tick_cnt_q;
    if (tick) tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
    if (tick && tick_cnt_q == TICK_S0) s0_d = rx_s;
    if (tick && tick_cnt_q == TICK_S1) s1_d = rx_s;

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d    = ST_START;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_d  = 1'b0;
`endif
        end
      end

      ST_START: begin
        if (resolve && bit_val) begin
          state_d = ST_IDLE;
        end else if (end_of_bit) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end

      ST_DATA: begin
        if (resolve) shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
        if (end_of_bit) begin
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        // Even parity: the parity bit must equal the XOR of the data bits.
        if (resolve)    par_bad_d = bit_val ^ (^shift_q);
        if (end_of_bit) state_d   = ST_STOP;
      end
`endif

      ST_STOP: begin
        // Decide mid-stop so a back-to-back start edge lands in IDLE.
        if (resolve) begin
          if (bit_val) begin
            state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              parity_err_d = 1'b1;
            end else begin
              data_d       = shift_q;
              data_valid_d = 1'b1;
            end
`else
            data_d       = shift_q;
            data_valid_d = 1'b1;
`endif
          end else begin
            framing_err_d = 1'b1;
            state_d       = ST_WAIT_IDLE;
            tick_cnt_d    = '0;
          end
        end
      end

      ST_WAIT_IDLE: begin
        // Need one full bit time of continuous high before trusting the line again.
        if (!rx_s) begin
          tick_cnt_d = '0;
        end else if (end_of_bit) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rx_sync_q     <= 2'b11;
      rx_prev_q     <= 1'b1;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      s0_q          <= 1'b1;
      s1_q          <= 1'b1;
      data_valid_q  <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_sync_q     <= {rx_sync_q[0], rx_if.RxD};
      rx_prev_q     <= rx_s;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      s0_q          <= s0_d;
      s1_q          <= s1_d;
      data_valid_q  <= data_valid_d;
      framing_err_q <= framing_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign rx_if.parity_err = parity_err_q;
`else
  assign rx_if.parity_err = 1'b0;
`endif

  assign rx_if.data        = data_q;
  assign rx_if.data_valid  = data_valid_q;
  assign rx_if.framing_err = framing_err_q;
  assign rx_if.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver; a small clock/baud ratio keeps each bit at 64 clocks.
// Build with UART_RX_PARITY_EN defined to exercise the parity frame format.
module tb_uart_receiver;
  localparam int CLK_FREQ = 614_400;
  localparam int BAUD     = 9600;
  localparam int OS       = 16;
  localparam int DIV      = CLK_FREQ / (BAUD * OS);
  localparam int BIT      = DIV * OS;
  localparam int LAT_MIN  = (OS / 2 + 1) * DIV;
  localparam int LAT_MAX  = (OS / 2 + 2) * DIV + 5;

  logic clk = 1'b0;
  logic reset;

  uart_receiver_if #(.DATA_BITS(8)) rx_if ();

  uart_receiver #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD),
    .DATA_BITS  (8),
    .OVERSAMPLE (OS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rx_if (rx_if)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int dv_cnt = 0, fe_cnt = 0, pe_cnt = 0, overlap_cnt = 0;
  int dv_cyc = 0, stop_cyc = 0;
  logic [7:0] hist[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_if.data_valid === 1'b1) begin
      dv_cnt++;
      dv_cyc = cyc;
      hist.push_back(rx_if.data);
    end
    if (rx_if.framing_err === 1'b1) fe_cnt++;
    if (rx_if.parity_err === 1'b1) pe_cnt++;
    if ((int'(rx_if.data_valid) + int'(rx_if.framing_err) + int'(rx_if.parity_err)) > 1)
      overlap_cnt++;
  end

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  // Called just after a posedge; returns just after a posedge.
  task automatic drive(input logic v, input int n);
    rx_if.RxD = v;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input logic par_lvl);
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(d[i], BIT);
`ifdef UART_RX_PARITY_EN
    drive(par_lvl, BIT);
`else
    if (par_lvl === 1'bx) drive(1'b1, 0);
`endif
    stop_cyc = cyc;
    drive(stop_lvl, BIT);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    rx_if.RxD = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (rx_if.data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", rx_if.data); end
    n_cmp++; if (rx_if.data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", rx_if.data_valid); end
    n_cmp++; if (rx_if.framing_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b want 0", rx_if.framing_err); end
    n_cmp++; if (rx_if.parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr got %b want 0", rx_if.parity_err); end
    n_cmp++; if (rx_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", rx_if.busy); end
    @(posedge clk);
    reset = 1'b0;
    repeat (BIT) @(posedge clk);
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int dv0 = dv_cnt, fe0 = fe_cnt, lat;
    send_frame(8'hA5, 1'b1, even_par(8'hA5));
    drive(1'b1, BIT);
    @(negedge clk);
    lat = dv_cyc - stop_cyc;
    n_cmp++; if (dv_cnt - dv0 !== 1) begin n_fail++; $display("FAIL basic_valid_count got %0d want 1", dv_cnt - dv0); end
    n_cmp++; if (rx_if.data !== 8'hA5) begin n_fail++; $display("FAIL basic_data got %h want a5", rx_if.data); end
    n_cmp++; if (rx_if.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy got %b want 0", rx_if.busy); end
    n_cmp++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL basic_ferr_count got %0d want 0", fe_cnt - fe0); end
    n_cmp++; if (lat < LAT_MIN || lat > LAT_MAX) begin n_fail++; $display("FAIL basic_latency got %0d want %0d..%0d", lat, LAT_MIN, LAT_MAX); end
    @(posedge clk);
    $display("test_basic: frame a5 data=%h latency=%0d", rx_if.data, lat);
  endtask

  task automatic test_glitch();
    int dv0 = dv_cnt, fe0 = fe_cnt, pe0 = pe_cnt;
    drive(1'b0, 3);
    drive(1'b1, 3);
    @(negedge clk);
    n_cmp++; if (rx_if.busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_high got %b want 1", rx_if.busy); end
    @(posedge clk);
    drive(1'b1, BIT);
    @(negedge clk);
    n_cmp++; if (rx_if.busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_low got %b want 0", rx_if.busy); end
    n_cmp++; if (dv_cnt - dv0 !== 0) begin n_fail++; $display("FAIL glitch_valid_count got %0d want 0", dv_cnt - dv0); end
    n_cmp++; if ((fe_cnt - fe0) + (pe_cnt - pe0) !== 0) begin n_fail++; $display("FAIL glitch_err_count got %0d want 0", (fe_cnt - fe0) + (pe_cnt - pe0)); end
    @(posedge clk);
    $display("test_glitch: 3-clk low pulse, busy=%b", rx_if.busy);
  endtask

  task automatic test_framing();
    int dv0 = dv_cnt, fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, even_par(8'h3C));
    drive(1'b0, 2 * BIT);
    @(negedge clk);
    n_cmp++; if (rx_if.busy !== 1'b1) begin n_fail++; $display("FAIL framing_busy_break got %b want 1", rx_if.busy); end
    @(posedge clk);
    drive(1'b1, 2 * BIT);
    @(negedge clk);
    n_cmp++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL framing_ferr_count got %0d want 1", fe_cnt - fe0); end
    n_cmp++; if (dv_cnt - dv0 !== 0) begin n_fail++; $display("FAIL framing_valid_count got %0d want 0", dv_cnt - dv0); end
    n_cmp++; if (rx_if.data !== 8'hA5) begin n_fail++; $display("FAIL framing_data_held got %h want a5", rx_if.data); end
    n_cmp++; if (rx_if.busy !== 1'b0) begin n_fail++; $display("FAIL framing_busy_idle got %b want 0", rx_if.busy); end
    @(posedge clk);
    send_frame(8'h81, 1'b1, even_par(8'h81));
    drive(1'b1, BIT);
    @(negedge clk);
    n_cmp++; if (dv_cnt - dv0 !== 1) begin n_fail++; $display("FAIL framing_next_valid got %0d want 1", dv_cnt - dv0); end
    n_cmp++; if (rx_if.data !== 8'h81) begin n_fail++; $display("FAIL framing_next_data got %h want 81", rx_if.data); end
    @(posedge clk);
    $display("test_framing: ferr=%0d then data=%h", fe_cnt - fe0, rx_if.data);
  endtask

  task automatic test_reset_midframe();
    int dv0, fe0, pe0;
    fork
      // Wrong parity bit keeps the tail of the aborted frame free of falling edges.
      send_frame(8'hFF, 1'b1, 1'b1);
      begin
        repeat (5 * BIT + 1) @(posedge clk);
        reset = 1'b1;
        @(posedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (rx_if.data !== 8'h00) begin n_fail++; $display("FAIL midreset_data got %h want 00", rx_if.data); end
        n_cmp++; if (rx_if.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", rx_if.busy); end
        n_cmp++; if ({rx_if.data_valid, rx_if.framing_err, rx_if.parity_err} !== 3'b000) begin
          n_fail++; $display("FAIL midreset_pulses got %b want 000", {rx_if.data_valid, rx_if.framing_err, rx_if.parity_err});
        end
        dv0 = dv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
      end
    join
    drive(1'b1, 2 * BIT);
    @(negedge clk);
    n_cmp++; if ((dv_cnt - dv0) + (fe_cnt - fe0) + (pe_cnt - pe0) !== 0) begin
      n_fail++; $display("FAIL midreset_tail_pulses got %0d want 0", (dv_cnt - dv0) + (fe_cnt - fe0) + (pe_cnt - pe0));
    end
    @(posedge clk);
    send_frame(8'h5A, 1'b1, even_par(8'h5A));
    drive(1'b1, BIT);
    @(negedge clk);
    n_cmp++; if (dv_cnt - dv0 !== 1) begin n_fail++; $display("FAIL midreset_next_valid got %0d want 1", dv_cnt - dv0); end
    n_cmp++; if (rx_if.data !== 8'h5A) begin n_fail++; $display("FAIL midreset_next_data got %h want 5a", rx_if.data); end
    @(posedge clk);
    $display("test_reset_midframe: recovered data=%h", rx_if.data);
  endtask

  task automatic test_back_to_back();
    int dv0 = dv_cnt;
    int h0  = hist.size();
    send_frame(8'h00, 1'b1, even_par(8'h00));
    send_frame(8'hFF, 1'b1, even_par(8'hFF));
    drive(1'b1, BIT);
    @(negedge clk);
    n_cmp++; if (dv_cnt - dv0 !== 2) begin n_fail++; $display("FAIL b2b_valid_count got %0d want 2", dv_cnt - dv0); end
    n_cmp++;
    if (hist.size() < h0 + 2) begin
      n_fail++; $display("FAIL b2b_words got %0d words want 2", hist.size() - h0);
    end else if (hist[h0] !== 8'h00 || hist[h0+1] !== 8'hFF) begin
      n_fail++; $display("FAIL b2b_words got %h,%h want 00,ff", hist[h0], hist[h0+1]);
    end
    @(posedge clk);
    $display("test_back_to_back: 00 then ff, valid pulses=%0d", dv_cnt - dv0);
  endtask

  task automatic test_parity();
`ifdef UART_RX_PARITY_EN
    int dv0 = dv_cnt, pe0 = pe_cnt;
    send_frame(8'h01, 1'b1, 1'b0);
    drive(1'b1, BIT);
    @(negedge clk);
    n_cmp++; if (pe_cnt - pe0 !== 1) begin n_fail++; $display("FAIL parity_bad_perr got %0d want 1", pe_cnt - pe0); end
    n_cmp++; if (dv_cnt - dv0 !== 0) begin n_fail++; $display("FAIL parity_bad_valid got %0d want 0", dv_cnt - dv0); end
    n_cmp++; if (rx_if.data !== 8'hFF) begin n_fail++; $display("FAIL parity_bad_data got %h want ff", rx_if.data); end
    @(posedge clk);
    send_frame(8'h01, 1'b1, 1'b1);
    drive(1'b1, BIT);
    @(negedge clk);
    n_cmp++; if (dv_cnt - dv0 !== 1) begin n_fail++; $display("FAIL parity_good_valid got %0d want 1", dv_cnt - dv0); end
    n_cmp++; if (rx_if.data !== 8'h01) begin n_fail++; $display("FAIL parity_good_data got %h want 01", rx_if.data); end
    @(posedge clk);
    $display("test_parity: bad-parity perr=%0d, good-parity data=%h", pe_cnt - pe0, rx_if.data);
`else
    @(negedge clk);
    n_cmp++; if (pe_cnt !== 0) begin n_fail++; $display("FAIL parity_tied got %0d pulses want 0", pe_cnt); end
    @(posedge clk);
    $display("test_parity: parity disabled, parity_err pulses=%0d", pe_cnt);
`endif
  endtask

  task automatic test_exclusive();
    @(negedge clk);
    n_cmp++; if (overlap_cnt !== 0) begin n_fail++; $display("FAIL exclusive_pulses got %0d overlaps want 0", overlap_cnt); end
    $display("test_exclusive: overlapping pulse cycles=%0d", overlap_cnt);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_reset_midframe();
    test_back_to_back();
    test_parity();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
